// File: rtl/parser_defs_pkg.sv
// Shared parser types and message-FIFO default sizing constants.
package parser_defs;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [11:0] length;
      logic [15:0] tag;
   } parsed_msg_t;

   localparam int MSG_FIFO_DEPTH_DFLT         = 16;
   // almost_full default sits this many entries below DEPTH
   localparam int MSG_FIFO_AFULL_MARGIN_DFLT  = 2;
   localparam int MSG_FIFO_AEMPTY_THRESH_DFLT = 2;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller gates the write enable.
module fifo_ram
   import parser_defs::*;
#(
   parameter int DEPTH = MSG_FIFO_DEPTH_DFLT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  parsed_msg_t       wdata,
   input  logic [AW-1:0]     raddr,
   output parsed_msg_t       rdata
);

   parsed_msg_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_msg_fifo.sv
// Single-clock FWFT FIFO of parsed messages; MSG_FIFO_DROP_CNT_EN adds a rejected-write counter.
// Latency: 1 cycle from write into an empty FIFO to out_valid.
// Backpressure: in_ready = !full, out_valid = !empty, both from registered count.
module sync_msg_fifo
   import parser_defs::*;
#(
   parameter int DEPTH         = MSG_FIFO_DEPTH_DFLT,
   parameter int AFULL_THRESH  = DEPTH - MSG_FIFO_AFULL_MARGIN_DFLT,
   parameter int AEMPTY_THRESH = MSG_FIFO_AEMPTY_THRESH_DFLT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  parsed_msg_t              msg_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output parsed_msg_t              msg_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
`ifdef MSG_FIFO_DROP_CNT_EN
   output logic                     almost_empty,
   output logic [15:0]              drop_cnt
`else
   output logic                     almost_empty
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);
   assign in_ready     = !full;
   assign out_valid    = !empty;

   assign wr_en = in_valid && in_ready;
   assign rd_en = out_valid && out_ready;

   // Power-of-two depth lets the pointers wrap naturally at DEPTH-1 -> 0
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en && reset && !flush),
      .waddr (wr_ptr),
      .wdata (msg_in),
      .raddr (rd_ptr),
      .rdata (msg_out)
   );

`ifdef MSG_FIFO_DROP_CNT_EN
   // Counts refused offers even in a flush cycle; only reset clears it
   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_cnt <= '0;
      end else if (in_valid && !in_ready && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/sync_msg_fifo.md
SYNC_MSG_FIFO -- requirements
Module: sync_msg_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of parsed_msg_t entries; power of two, 2..1024.
REQ-002 SHALL have parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= this value.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= this value.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-006 SHALL have port flush, input, 1: synchronous clear of contents.
REQ-007 SHALL have port in_valid, input, 1: producer offers msg_in.
REQ-008 SHALL have port in_ready, output, 1: FIFO accepts msg_in this cycle.
REQ-009 SHALL have port msg_in, input, parsed_msg_t: write data.
REQ-010 SHALL have port out_valid, output, 1: msg_out holds the oldest entry.
REQ-011 SHALL have port out_ready, input, 1: consumer takes msg_out this cycle.
REQ-012 SHALL have port msg_out, output, parsed_msg_t: head entry, first-word-fall-through.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: entries stored, 0..DEPTH.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty, output, 1 each: status flags.
REQ-015 SHALL have port drop_cnt, output, 16, present only under MSG_FIFO_DROP_CNT_EN: rejected writes.

Function
REQ-016 SHALL perform a write when in_valid && in_ready; SHALL perform a read when out_valid && out_ready.
REQ-017 SHALL drive in_ready = !full and out_valid = !empty; no combinational path from out_ready to in_ready.
REQ-018 SHALL present a written entry on msg_out one cycle after its write when the FIFO was empty (latency 1).
REQ-019 SHALL keep msg_out stable while out_valid && !out_ready.
REQ-020 SHALL wrap pointers modulo DEPTH using $clog2(DEPTH)-bit pointers; no off-by-one at index DEPTH-1.
REQ-021 SHALL on simultaneous write and read leave count unchanged and advance both pointers.
REQ-022 SHALL when full ignore writes even if a read occurs in that cycle; the read still completes.
REQ-023 SHALL when empty ignore out_ready; count never underflows.
REQ-024 SHALL derive full = (count == DEPTH), empty = (count == 0), almost_full/almost_empty from registered count only.
REQ-025 SHALL on flush set pointers and count to 0 on the next edge, discarding any same-cycle write or read; flush has priority over both.
REQ-026 SHALL leave msg_out undefined (don't-care) when out_valid is 0.

Reset
REQ-027 SHALL on reset low at a clock edge set pointers and count to 0, empty=1, full=0, almost_empty=1, almost_full=0, in_ready=1, out_valid=0, drop_cnt=0.
REQ-028 SHALL not reset storage contents; reset mid-operation discards all entries.
REQ-029 SHALL ignore in_valid/out_ready/flush in any cycle reset is low.

Configuration
REQ-030 SHALL with MSG_FIFO_DROP_CNT_EN defined increment drop_cnt on each cycle with in_valid && !in_ready, saturating at 16'hFFFF, cleared by reset only (not by flush).
REQ-031 SHALL without MSG_FIFO_DROP_CNT_EN omit drop_cnt port and its logic entirely.

Structure
REQ-032 SHALL take parsed_msg_t from the shared parser_defs package; no local redefinition.
REQ-033 SHALL place default DEPTH and threshold constants in parser_defs as MSG_FIFO_DEPTH_DFLT etc.
REQ-034 SHALL instantiate one sub-module fifo_ram (simple dual-port, 1 write port, asynchronous read) for storage.

Verification
REQ-035 SHALL cover fill: DEPTH=16, 16 writes no reads -> count=16, full=1, in_ready=0, 17th write dropped, drop_cnt=1.
REQ-036 SHALL cover wrap: 40 writes with interleaved reads -> read order identical to write order across 2+ pointer wraps.
REQ-037 SHALL cover simultaneous: count=5, write+read same cycle -> count stays 5, head advances by one.
REQ-038 SHALL cover full+read: count=16, in_valid=1, out_ready=1 -> count=15, write rejected, drop_cnt increments.
REQ-039 SHALL cover flush: count=9, flush with in_valid=1 -> next cycle count=0, empty=1, drop_cnt unchanged.
REQ-040 SHALL cover reset mid-stream: count=7, reset low one cycle -> all outputs at REQ-027 values next cycle.
